// File: rtl/ks10_trace_buffer.sv
// KS10 instruction trace buffer: captures {PC,HR} on each regsLOAD into a
// circular RAM under console arm/trigger/stop control; console pops oldest-first.
// Optional feature macro: TRACE_HALTSTOP_EN (rising cpuHALT in ARMED/CAPTURE -> DONE).
module ks10_trace_buffer #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [18:35]          cpuPC,
  input  logic [0:35]           cpuHR,
  input  logic                  regsLOAD,
  input  logic                  cpuHALT,
  input  logic                  trcARM,
  input  logic                  trcCLR,
  input  logic                  trcSTOP,
  input  logic                  trcWRAP,
  input  logic                  trcMATCHEN,
  input  logic [18:35]          trcTRIGADDR,
  input  logic                  trcREAD,
  output logic [0:53]           trcDATA,
  output logic                  trcEMPTY,
  output logic                  trcFULL,
  output logic                  trcOVF,
  output logic [DEPTH_LOG2:0]   trcCOUNT,
  output logic [0:1]            trcSTATE
);

  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned EW    = 54;
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [EW-1:0]   data_q;
  logic [EW-1:0]   mem [DEPTH];

  logic empty, full, trig, wr_req, do_write, do_pop, halt_rise;

`ifdef TRACE_HALTSTOP_EN
  logic halt_q;

  // Delayed halt for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) halt_q <= 1'b0;
    else      halt_q <= cpuHALT;
  end

  assign halt_rise = cpuHALT & ~halt_q;
`else
  logic unused_halt;
  assign unused_halt = cpuHALT;
  assign halt_rise   = 1'b0;
`endif

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign trig     = regsLOAD & (~trcMATCHEN | (cpuPC == trcTRIGADDR));
  assign wr_req   = ~trcCLR & (((state_q == ST_ARMED) & trig) |
                               ((state_q == ST_CAPTURE) & regsLOAD));
  // Full without wrap drops the write; the FSM moves to DONE instead.
  assign do_write = wr_req & (~full | trcWRAP);
  assign do_pop   = ~trcCLR & trcREAD & ~empty;

  // Capture FSM next state; clear beats stop beats everything else
  always_comb begin
    state_d = state_q;
    if (trcCLR) begin
      state_d = ST_IDLE;
    end else if (trcSTOP && (state_q == ST_ARMED || state_q == ST_CAPTURE)) begin
      state_d = ST_DONE;
    end else begin
      unique case (state_q)
        ST_IDLE:    if (trcARM) state_d = ST_ARMED;
        ST_ARMED: begin
          if (trig)      state_d = ST_CAPTURE;
          if (halt_rise) state_d = ST_DONE;
        end
        ST_CAPTURE: if ((full && !trcWRAP && regsLOAD) || halt_rise) state_d = ST_DONE;
        ST_DONE:    if (trcARM) state_d = ST_ARMED;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Pointer, occupancy and overflow bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (trcCLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
      // A wrapping write on a full buffer discards the oldest entry; a pop in
      // the same clock consumes that same entry, so advance only once.
      if (do_pop || (do_write && full)) rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_write && full && !do_pop) ovf_d = 1'b1;
      if (do_write && !full && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_write)          count_d = count_q - CW'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Trace RAM write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= {cpuPC, cpuHR};
  end

  // Registered read of the oldest entry, refreshed while the buffer holds data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        data_q <= '0;
    else if (!empty) data_q <= mem[rd_ptr_q];
  end

  assign trcDATA  = data_q;
  assign trcEMPTY = empty;
  assign trcFULL  = full;
  assign trcOVF   = ovf_q;
  assign trcCOUNT = count_q;
  assign trcSTATE = state_q;

endmodule

// File: tb/tb_ks10_trace_buffer.sv
// Directed bench for ks10_trace_buffer built with an 8-entry buffer.
module tb_ks10_trace_buffer;

  logic         clk;
  logic         rst;
  logic [18:35] cpuPC;
  logic [0:35]  cpuHR;
  logic         regsLOAD, cpuHALT, trcARM, trcCLR, trcSTOP, trcWRAP, trcMATCHEN, trcREAD;
  logic [18:35] trcTRIGADDR;
  logic [0:53]  trcDATA;
  logic         trcEMPTY, trcFULL, trcOVF;
  logic [3:0]   trcCOUNT;
  logic [0:1]   trcSTATE;

  int checks = 0;
  int errors = 0;

  ks10_trace_buffer #(.DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .cpuPC(cpuPC), .cpuHR(cpuHR), .regsLOAD(regsLOAD),
    .cpuHALT(cpuHALT), .trcARM(trcARM), .trcCLR(trcCLR), .trcSTOP(trcSTOP),
    .trcWRAP(trcWRAP), .trcMATCHEN(trcMATCHEN), .trcTRIGADDR(trcTRIGADDR),
    .trcREAD(trcREAD), .trcDATA(trcDATA), .trcEMPTY(trcEMPTY), .trcFULL(trcFULL),
    .trcOVF(trcOVF), .trcCOUNT(trcCOUNT), .trcSTATE(trcSTATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] hr_of(input logic [17:0] pc);
    return {pc, ~pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [17:0] pc, input logic rd);
    cpuPC = pc; cpuHR = hr_of(pc); regsLOAD = 1'b1; trcREAD = rd;
    step();
    regsLOAD = 1'b0; trcREAD = 1'b0;
  endtask

  task automatic pulse_arm();
    trcARM = 1'b1; step(); trcARM = 1'b0;
  endtask

  task automatic pulse_clr();
    trcCLR = 1'b1; step(); trcCLR = 1'b0;
  endtask

  task automatic pop();
    trcREAD = 1'b1; step(); trcREAD = 1'b0;
  endtask

  // Pop n entries checking PC first..first+n-1 (one idle clock for prefetch)
  task automatic drain_check(input string name, input logic [17:0] first, input int n);
    logic [17:0] exp;
    step();
    for (int i = 0; i < n; i++) begin
      exp = first + 18'(i);
      checks++;
      if (trcDATA[0:17] !== exp) begin
        errors++;
        $display("FAIL %s_pop%0d got %0d exp %0d", name, i, trcDATA[0:17], exp);
      end
      pop();
      step();
    end
    checks++;
    if (trcEMPTY !== 1'b1 || trcCOUNT !== 4'd0) begin
      errors++;
      $display("FAIL %s_empty got empty=%b count=%0d exp empty=1 count=0", name, trcEMPTY, trcCOUNT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; cpuPC = '0; cpuHR = '0; regsLOAD = 0; cpuHALT = 0; trcARM = 0;
    trcCLR = 0; trcSTOP = 0; trcWRAP = 0; trcMATCHEN = 0; trcTRIGADDR = '0; trcREAD = 0;
    step(); step();
    checks++;
    if (trcSTATE !== 2'd0 || trcCOUNT !== 4'd0 || trcEMPTY !== 1'b1 || trcFULL !== 1'b0 ||
        trcOVF !== 1'b0 || trcDATA !== 54'd0) begin
      errors++;
      $display("FAIL reset got st=%0d cnt=%0d e=%b f=%b o=%b d=%h exp 0 0 1 0 0 0",
               trcSTATE, trcCOUNT, trcEMPTY, trcFULL, trcOVF, trcDATA);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [53:0] exp;
    pulse_arm();
    checks++;
    if (trcSTATE !== 2'd1) begin errors++; $display("FAIL basic_armed got %0d exp 1", trcSTATE); end
    load(18'd100, 0); load(18'd101, 0); load(18'd102, 0);
    checks++;
    if (trcCOUNT !== 4'd3 || trcSTATE !== 2'd2) begin
      errors++; $display("FAIL basic_count got cnt=%0d st=%0d exp cnt=3 st=2", trcCOUNT, trcSTATE);
    end
    step();
    exp = {18'd100, hr_of(18'd100)};
    checks++;
    if (trcDATA !== exp) begin errors++; $display("FAIL basic_data got %h exp %h", trcDATA, exp); end
    drain_check("basic", 18'd100, 3);
    pop();
    checks++;
    if (trcCOUNT !== 4'd0 || trcEMPTY !== 1'b1) begin
      errors++; $display("FAIL basic_pop_empty got cnt=%0d exp 0", trcCOUNT);
    end
    pulse_clr();
  endtask

  task automatic test_match();
    trcMATCHEN = 1'b1; trcTRIGADDR = 18'd2000;
    pulse_arm();
    load(18'd1776, 0); load(18'd1777, 0);
    checks++;
    if (trcCOUNT !== 4'd0 || trcSTATE !== 2'd1) begin
      errors++; $display("FAIL match_pre got cnt=%0d st=%0d exp cnt=0 st=1", trcCOUNT, trcSTATE);
    end
    load(18'd2000, 0); load(18'd2001, 0);
    checks++;
    if (trcCOUNT !== 4'd2 || trcSTATE !== 2'd2) begin
      errors++; $display("FAIL match_post got cnt=%0d st=%0d exp cnt=2 st=2", trcCOUNT, trcSTATE);
    end
    drain_check("match", 18'd2000, 2);
    trcMATCHEN = 1'b0;
    pulse_clr();
  endtask

  task automatic test_nowrap();
    trcWRAP = 1'b0;
    pulse_arm();
    for (int i = 1; i <= 10; i++) load(18'(i), 0);
    checks++;
    if (trcCOUNT !== 4'd8 || trcFULL !== 1'b1 || trcSTATE !== 2'd3 || trcOVF !== 1'b0) begin
      errors++;
      $display("FAIL nowrap got cnt=%0d f=%b st=%0d o=%b exp cnt=8 f=1 st=3 o=0",
               trcCOUNT, trcFULL, trcSTATE, trcOVF);
    end
    drain_check("nowrap", 18'd1, 8);
    pulse_clr();
  endtask

  task automatic test_wrap();
    trcWRAP = 1'b1;
    pulse_arm();
    for (int i = 1; i <= 10; i++) load(18'(i), 0);
    checks++;
    if (trcCOUNT !== 4'd8 || trcOVF !== 1'b1 || trcSTATE !== 2'd2) begin
      errors++;
      $display("FAIL wrap got cnt=%0d o=%b st=%0d exp cnt=8 o=1 st=2", trcCOUNT, trcOVF, trcSTATE);
    end
    drain_check("wrap", 18'd3, 8);
    pulse_clr();
    checks++;
    if (trcOVF !== 1'b0 || trcSTATE !== 2'd0) begin
      errors++; $display("FAIL wrap_clr got o=%b st=%0d exp o=0 st=0", trcOVF, trcSTATE);
    end
  endtask

  task automatic test_back_to_back();
    trcWRAP = 1'b1;
    pulse_arm();
    pop();
    checks++;
    if (trcCOUNT !== 4'd0 || trcEMPTY !== 1'b1) begin
      errors++; $display("FAIL b2b_emptyread got cnt=%0d exp 0", trcCOUNT);
    end
    load(18'd500, 1);
    checks++;
    if (trcCOUNT !== 4'd1 || trcEMPTY !== 1'b0) begin
      errors++; $display("FAIL b2b_empty got cnt=%0d exp 1", trcCOUNT);
    end
    step();
    checks++;
    if (trcDATA[0:17] !== 18'd500) begin
      errors++; $display("FAIL b2b_data got %0d exp 500", trcDATA[0:17]);
    end
    for (int i = 1; i <= 7; i++) load(18'(500 + i), 0);
    load(18'd508, 1);
    checks++;
    if (trcCOUNT !== 4'd8 || trcOVF !== 1'b0 || trcFULL !== 1'b1) begin
      errors++; $display("FAIL b2b_full got cnt=%0d o=%b exp cnt=8 o=0", trcCOUNT, trcOVF);
    end
    drain_check("b2b", 18'd501, 8);
    pulse_clr();
  endtask

  task automatic test_reset_mid();
    trcWRAP = 1'b1;
    pulse_arm();
    for (int i = 0; i < 9; i++) load(18'(700 + i), 0);
    rst = 1'b0; cpuPC = 18'd777; cpuHR = hr_of(18'd777); regsLOAD = 1'b1;
    step();
    checks++;
    if (trcSTATE !== 2'd0 || trcCOUNT !== 4'd0 || trcEMPTY !== 1'b1 || trcFULL !== 1'b0 ||
        trcOVF !== 1'b0 || trcDATA !== 54'd0) begin
      errors++;
      $display("FAIL rstmid got st=%0d cnt=%0d e=%b f=%b o=%b d=%h exp 0 0 1 0 0 0",
               trcSTATE, trcCOUNT, trcEMPTY, trcFULL, trcOVF, trcDATA);
    end
    rst = 1'b1;
    step();
    regsLOAD = 1'b0;
    checks++;
    if (trcCOUNT !== 4'd0 || trcSTATE !== 2'd0) begin
      errors++; $display("FAIL rstmid_idle got cnt=%0d st=%0d exp 0 0", trcCOUNT, trcSTATE);
    end
  endtask

`ifdef TRACE_HALTSTOP_EN
  task automatic test_halt();
    pulse_arm();
    load(18'd40, 0);
    cpuHALT = 1'b1;
    load(18'd41, 0);
    checks++;
    if (trcSTATE !== 2'd3 || trcCOUNT !== 4'd2) begin
      errors++; $display("FAIL halt got st=%0d cnt=%0d exp st=3 cnt=2", trcSTATE, trcCOUNT);
    end
    cpuHALT = 1'b0;
    pulse_clr();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_match();
    test_nowrap();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef TRACE_HALTSTOP_EN
    test_halt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
